// File: rtl/abs_bcd_conv.sv
// Sequential binary-to-BCD converter for the abs stage output (sign + 7-bit magnitude).
// Double dabble, one shift per clock, start/busy/done handshake, all outputs registered.
module abs_bcd_conv (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sign,
    input  logic [6:0] magnitude,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t      r_state;
    logic [19:0] r_work;         // {hundreds, tens, ones, binary}
    logic [2:0]  r_count;
    logic        r_neg_pending;
    logic        r_busy;
    logic        r_done;
    logic        r_neg;
    logic [3:0]  r_hundreds;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    logic [7:0]  w_value8;
    logic [19:0] w_adjusted;
    logic [19:0] w_shifted;

    function automatic logic [3:0] add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

    // sign with a zero magnitude is -128, which the 7-bit abs result cannot carry.
    assign w_value8 = {sign & (magnitude == 7'd0), magnitude};

    assign w_adjusted = {add3(r_work[19:16]), add3(r_work[15:12]), add3(r_work[11:8]), r_work[7:0]};
    assign w_shifted  = w_adjusted << 1;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_work        <= '0;
            r_count       <= '0;
            r_neg_pending <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_neg         <= 1'b0;
            r_hundreds    <= '0;
            r_tens        <= '0;
            r_ones        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work        <= {12'd0, w_value8};
                        r_neg_pending <= sign;
                        r_count       <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count + 3'd1;
                    // Digits update only on the last step, so the display never sees partial values.
                    if (r_count == 3'd7) begin
                        r_hundreds <= w_shifted[19:16];
                        r_tens     <= w_shifted[15:12];
                        r_ones     <= w_shifted[11:8];
                        r_neg      <= r_neg_pending;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign neg          = r_neg;
    assign bcd_hundreds = r_hundreds;
    assign bcd_tens     = r_tens;
    assign bcd_ones     = r_ones;

    a_done_not_busy: assert property (@(posedge clk) disable iff (!reset) r_done |-> !r_busy);
    a_done_single:   assert property (@(posedge clk) disable iff (!reset) r_done |=> !r_done);

endmodule
